// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - fixed-latency word memory that answers cache read/write requests
// One transaction in flight; response pulses LATENCY edges after acceptance.
module cache_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        wr_mem,
  input  logic [31:0] cache_to_mem_address,
  input  logic [31:0] cache_to_mem_data,
  output logic [31:0] mem_to_cache_data,
  output logic        rd_valid,
  output logic        wr_done,
  output logic [15:0] txn_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rd_valid_q, rd_valid_d;
  logic               wr_done_q, wr_done_d;
  logic [15:0]        txn_q, txn_d;
  logic               commit_wr;

  logic [31:0]        mem_q [DEPTH];

  // Byte offset and high address bits play no part in the word index.
  logic unused_addr;
  assign unused_addr = ^{cache_to_mem_address[31:IDX_W+2], cache_to_mem_address[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;
    wr_done_d  = 1'b0;
    txn_d      = txn_q;
    commit_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
          wr_d    = wr_mem;
          idx_d   = cache_to_mem_address[IDX_W+1:2];
          wdata_d = cache_to_mem_data;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          txn_d   = txn_q + 16'd1;
          if (wr_q) begin
            wr_done_d = 1'b1;
            commit_wr = 1'b1;
          end else begin
            rd_valid_d = 1'b1;
            rdata_d    = mem_q[idx_q];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      txn_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
      txn_q      <= txn_d;
    end
  end

  // Storage is never cleared; the rst term keeps an aborted write from landing.
  always_ff @(posedge clk) begin
    if (commit_wr && !rst) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign req_ready         = (state_q == IDLE) && !rst;
  assign rd_valid          = rd_valid_q;
  assign wr_done           = wr_done_q;
  assign mem_to_cache_data = rdata_q;
  assign txn_count         = txn_q;

endmodule
